// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: sequential advance, stall, relative branch,
// absolute jump, trap entry/return with saved exception PC and misaligned-target detection.
module pc_unit #(
   parameter int unsigned          PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'('h100),
   parameter int unsigned          INSTR_BYTES  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                branch_take,
   input  logic [PC_WIDTH-1:0] branch_offset,
   input  logic                jump_take,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                trap_req,
   input  logic                trap_ret,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus,
   output logic [PC_WIDTH-1:0] epc,
   output logic                in_trap,
   output logic                misaligned_err
);

   localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } state_t;

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] r_epc;
   logic                r_mis;

   logic [PC_WIDTH-1:0] w_pc_plus;
   logic [PC_WIDTH-1:0] w_target;
   logic                w_target_mis;

   // Jump outranks branch, so the candidate target follows the same order.
   assign w_pc_plus    = r_pc + STEP;
   assign w_target     = jump_take ? jump_target : (r_pc + branch_offset);
   assign w_target_mis = |(w_target & ALIGN_MASK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_VECTOR;
         r_epc   <= '0;
         r_mis   <= 1'b0;
      end else begin
         r_mis <= 1'b0;
         if (trap_req && (r_state == ST_RUN)) begin
            // Trap entry is honoured even while stalled.
            r_epc   <= r_pc;
            r_pc    <= TRAP_VECTOR;
            r_state <= ST_TRAP;
         end else if (en) begin
            if (trap_ret && (r_state == ST_TRAP)) begin
               r_pc    <= r_epc;
               r_state <= ST_RUN;
            end else if (jump_take || branch_take) begin
               if (w_target_mis) begin
                  r_mis <= 1'b1;
                  if (r_state == ST_RUN) begin
                     r_epc   <= r_pc;
                     r_pc    <= TRAP_VECTOR;
                     r_state <= ST_TRAP;
                  end
               end else begin
                  r_pc <= w_target;
               end
            end else begin
               r_pc <= w_pc_plus;
            end
         end
      end
   end

   assign pc             = r_pc;
   assign pc_plus        = w_pc_plus;
   assign epc            = r_epc;
   assign in_trap        = (r_state == ST_TRAP);
   assign misaligned_err = r_mis;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: a 32-bit/4-byte instance and a 16-bit/2-byte instance.
module tb_pc_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        reset, en, br, jp, tr, tret;
   logic [31:0] br_off, jp_tgt;
   logic [31:0] pc, pc_plus, epc;
   logic        in_trap, mis;

   logic        b_reset, b_en, b_br, b_jp, b_tr, b_tret;
   logic [15:0] b_br_off, b_jp_tgt;
   logic [15:0] b_pc, b_pc_plus, b_epc;
   logic        b_in_trap, b_mis;

   pc_unit #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .INSTR_BYTES(4)) u_a (
      .clk(clk), .reset(reset), .en(en),
      .branch_take(br), .branch_offset(br_off),
      .jump_take(jp), .jump_target(jp_tgt),
      .trap_req(tr), .trap_ret(tret),
      .pc(pc), .pc_plus(pc_plus), .epc(epc),
      .in_trap(in_trap), .misaligned_err(mis)
   );

   pc_unit #(.PC_WIDTH(16), .RESET_VECTOR(16'h0), .TRAP_VECTOR(16'h100), .INSTR_BYTES(2)) u_b (
      .clk(clk), .reset(b_reset), .en(b_en),
      .branch_take(b_br), .branch_offset(b_br_off),
      .jump_take(b_jp), .jump_target(b_jp_tgt),
      .trap_req(b_tr), .trap_ret(b_tret),
      .pc(b_pc), .pc_plus(b_pc_plus), .epc(b_epc),
      .in_trap(b_in_trap), .misaligned_err(b_mis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; br = 1'b0; jp = 1'b0; tr = 1'b0; tret = 1'b0;
      br_off = '0; jp_tgt = '0;
   endtask

   task automatic jump_to(input logic [31:0] t);
      idle(); jp = 1'b1; jp_tgt = t;
      tick();
      idle();
   endtask

   task automatic state_a(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                          input logic e_trap, input logic e_mis);
      chk({tag, "_pc"}, pc, e_pc);
      chk({tag, "_epc"}, epc, e_epc);
      chk({tag, "_trap"}, 32'(in_trap), 32'(e_trap));
      chk({tag, "_mis"}, 32'(mis), 32'(e_mis));
   endtask

   initial begin
      idle(); en = 1'b0; reset = 1'b1;
      b_reset = 1'b1; b_en = 1'b0; b_br = 1'b0; b_jp = 1'b0; b_tr = 1'b0; b_tret = 1'b0;
      b_br_off = '0; b_jp_tgt = '0;
      #12;
      state_a("reset", 32'h0, 32'h0, 1'b0, 1'b0);
      chk("reset_pcplus", pc_plus, 32'h4);
      tick(); // inputs ignored while reset is held
      chk("reset_hold_pc", pc, 32'h0);

      // Sequential advance
      reset = 1'b0; idle();
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("seq%0d_pc", i), pc, 32'(4 * i));
         chk($sformatf("seq%0d_pcplus", i), pc_plus, 32'(4 * i + 4));
         chk($sformatf("seq%0d_trap", i), 32'(in_trap), 32'h0);
      end

      // trap_ret in RUN is ignored: sequential step instead
      tret = 1'b1; tick(); idle();
      chk("ret_in_run_pc", pc, 32'h14);

      // Backward branch
      jump_to(32'h20);
      chk("jump20", pc, 32'h20);
      br = 1'b1; br_off = 32'hFFFF_FFF8; tick(); idle();
      chk("branch_m8", pc, 32'h18);

      // Branch wrap below zero, then sequential wrap back to zero
      jump_to(32'h0);
      br = 1'b1; br_off = 32'hFFFF_FFFC; tick(); idle();
      chk("branch_wrap", pc, 32'hFFFF_FFFC);
      chk("pcplus_wrap", pc_plus, 32'h0);
      tick();
      chk("seq_wrap", pc, 32'h0);

      // Jump beats branch; stall holds pc and ignores jump
      jump_to(32'h40);
      jp = 1'b1; jp_tgt = 32'h80; br = 1'b1; br_off = 32'h8; tick(); idle();
      chk("jump_wins", pc, 32'h80);
      en = 1'b0; jp = 1'b1; jp_tgt = 32'h200;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall%0d_pc", i), pc, 32'h80);
      end
      idle();

      // Trap entry, nested request ignored, return
      jump_to(32'h1C);
      tr = 1'b1; tick(); idle();
      state_a("trap_entry", 32'h100, 32'h1C, 1'b1, 1'b0);
      tr = 1'b1; tick(); idle();
      state_a("trap_nested", 32'h104, 32'h1C, 1'b1, 1'b0);
      tret = 1'b1; tick(); idle();
      state_a("trap_ret", 32'h1C, 32'h1C, 1'b0, 1'b0);

      // Misaligned jump in RUN -> trap with one-cycle error pulse
      jump_to(32'h30);
      jp = 1'b1; jp_tgt = 32'h42; tick(); idle();
      state_a("mis_run", 32'h100, 32'h30, 1'b1, 1'b1);
      tick();
      state_a("mis_pulse_end", 32'h104, 32'h30, 1'b1, 1'b0);
      tret = 1'b1; tick(); idle();
      chk("mis_ret_pc", pc, 32'h30);
      tick();
      chk("seq_34", pc, 32'h34);

      // trap_req together with misaligned jump: trap wins, no error
      jp = 1'b1; jp_tgt = 32'h42; tr = 1'b1; tick(); idle();
      state_a("trap_vs_mis", 32'h100, 32'h34, 1'b1, 1'b0);

      // Misaligned branch in TRAP: pc holds, pulse, stay in TRAP
      br = 1'b1; br_off = 32'h2; tick(); idle();
      state_a("mis_trap", 32'h100, 32'h34, 1'b1, 1'b1);
      tick(); tick();
      state_a("trap_108", 32'h108, 32'h34, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle
      #2 reset = 1'b1;
      #1;
      state_a("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk); reset = 1'b0; idle();

      // Stalled trap_req is still honoured
      tick();
      chk("pre_stall_trap", pc, 32'h4);
      en = 1'b0; tr = 1'b1; tick(); idle();
      state_a("stall_trap", 32'h100, 32'h4, 1'b1, 1'b0);

      // 16-bit, 2-byte instance
      en = 1'b0;
      chk("b_reset_pc", 32'(b_pc), 32'h0);
      b_reset = 1'b0; b_en = 1'b1;
      tick();
      chk("b_seq_pc", 32'(b_pc), 32'h2);
      chk("b_seq_pcplus", 32'(b_pc_plus), 32'h4);
      b_jp = 1'b1; b_jp_tgt = 16'hFFFE; tick(); b_jp = 1'b0;
      chk("b_jump_fffe", 32'(b_pc), 32'hFFFE);
      chk("b_pcplus_wrap", 32'(b_pc_plus), 32'h0);
      tick();
      chk("b_seq_wrap", 32'(b_pc), 32'h0);
      b_jp = 1'b1; b_jp_tgt = 16'h0003; tick(); b_jp = 1'b0;
      chk("b_mis_pc", 32'(b_pc), 32'h100);
      chk("b_mis_epc", 32'(b_epc), 32'h0);
      chk("b_mis_err", 32'(b_mis), 32'h1);
      chk("b_mis_trap", 32'(b_in_trap), 32'h1);
      tick();
      chk("b_mis_end", 32'(b_mis), 32'h0);
      chk("b_trap_seq", 32'(b_pc), 32'h102);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
